// File: rtl/div_pkg.sv
// Shared widths, iteration count and FSM state encoding for the sequential divider.
package div_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int ITER_N     = 8;

  localparam logic [3:0] LAST_ITER = 4'(ITER_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare,
// and conditionally subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] rem_o,
  output logic                 q_o
);

  logic [DIVISOR_W:0] partial_s;
  logic [DIVISOR_W:0] diff_s;

  // Compare the widened partial remainder and subtract when it covers the divisor.
  always_comb begin
    partial_s = {rem_i, bit_i};
    diff_s    = partial_s - {1'b0, divisor_i};
    if (partial_s >= {1'b0, divisor_i}) begin
      rem_o = diff_s[DIVISOR_W-1:0];
      q_o   = 1'b1;
    end else begin
      rem_o = partial_s[DIVISOR_W-1:0];
      q_o   = 1'b0;
    end
  end

endmodule

// File: rtl/seq_div_4bit.sv
// 8-bit / 4-bit unsigned sequential restoring divider, one quotient bit per cycle.
// Optional DIV_ZERO_FLAG_EN adds a 1-cycle divide-by-zero path and the div_zero flag.
module seq_div_4bit
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
`ifdef DIV_ZERO_FLAG_EN
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
`else
  output logic [DIVISOR_W-1:0]  remainder
`endif
);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]    rem_q, rem_d;
  logic [DIVIDEND_W-2:0]   qacc_q, qacc_d;
  logic [DIVIDEND_W-1:0]   quot_q, quot_d;
  logic [DIVISOR_W-1:0]    remo_q, remo_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    dz_q, dz_d;

  logic [DIVISOR_W-1:0]    step_rem_s;
  logic                    step_q_s;

  div_step u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[DIVIDEND_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem_s),
    .q_o       (step_q_s)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qacc_d  = qacc_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          cnt_d  = 4'd0;
          rem_d  = 4'd0;
          qacc_d = 7'd0;
`ifdef DIV_ZERO_FLAG_EN
          if (divisor == 4'd0) begin
            state_d = DONE;
            quot_d  = 8'hFF;
            remo_d  = 4'hF;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
          end
`else
          state_d = RUN;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        dvd_d  = {dvd_q[DIVIDEND_W-2:0], 1'b0};
        rem_d  = step_rem_s;
        qacc_d = {qacc_q[DIVIDEND_W-3:0], step_q_s};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          dz_d    = 1'b0;
          // A zero divisor saturates the quotient; the remainder is forced to all-ones.
          if (dvs_q == 4'd0) begin
            quot_d = 8'hFF;
            remo_d = 4'hF;
          end else begin
            quot_d = {qacc_q, step_q_s};
            remo_d = step_rem_s;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, working and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      rem_q   <= 4'd0;
      qacc_q  <= 7'd0;
      quot_q  <= 8'd0;
      remo_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qacc_q  <= qacc_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero  = dz_q;
`else
  logic unused_dz_s;
  assign unused_dz_s = dz_q;
`endif

endmodule

// File: tb/tb_seq_div_4bit.sv
// Directed and sweep bench for seq_div_4bit; honours DIV_ZERO_FLAG_EN.
module tb_seq_div_4bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic       div_zero;
`endif

  int vectors;
  int miscompares;

  seq_div_4bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
`ifdef DIV_ZERO_FLAG_EN
    .remainder (remainder),
    .div_zero  (div_zero)
`else
    .remainder (remainder)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller is at a negedge; returns at the negedge where done is seen (or timeout).
  task automatic run_op(input logic [7:0] dd, input logic [3:0] ds,
                        output int lat, output logic [7:0] q, output logic [3:0] r);
    dividend = dd;
    divisor  = ds;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    q = quotient;
    r = remainder;
  endtask

  task automatic test_reset;
    int lat;
    rst_n = 1'b0;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 4'd0;
    #3;
    vectors++;
    if ({busy, done, quotient, remainder} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h, want all zero", busy, done, quotient, remainder);
    end
`ifdef DIV_ZERO_FLAG_EN
    vectors++;
    if (div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_div_zero: got %b want 0", div_zero);
    end
`endif
    // Start is already high when reset releases: the first edge must accept it.
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL first_edge_start: busy got %b want 1", busy);
    end
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (lat !== 9 || quotient !== 8'd28 || remainder !== 4'd4) begin
      miscompares++;
      $display("FAIL first_op_after_reset: got lat=%0d q=%0d r=%0d want lat=9 q=28 r=4", lat, quotient, remainder);
    end
  endtask

  task automatic test_basic;
    int lat;
    logic [7:0] q;
    logic [3:0] r;
    @(negedge clk);
    run_op(8'd200, 4'd7, lat, q, r);
    vectors++;
    if (lat !== 9 || q !== 8'd28 || r !== 4'd4) begin
      miscompares++;
      $display("FAIL div_200_7: got lat=%0d q=%0d r=%0d want lat=9 q=28 r=4", lat, q, r);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_in_done: got %b want 0", busy);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_one_cycle: got %b want 0", done);
    end
    run_op(8'd255, 4'd1, lat, q, r);
    vectors++;
    if (q !== 8'd255 || r !== 4'd0) begin
      miscompares++;
      $display("FAIL div_255_1: got q=%0d r=%0d want q=255 r=0", q, r);
    end
    @(negedge clk);
    run_op(8'd5, 4'd15, lat, q, r);
    vectors++;
    if (q !== 8'd0 || r !== 4'd5) begin
      miscompares++;
      $display("FAIL div_5_15: got q=%0d r=%0d want q=0 r=5", q, r);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    int exp_lat;
    logic [7:0] q;
    logic [3:0] r;
`ifdef DIV_ZERO_FLAG_EN
    exp_lat = 1;
`else
    exp_lat = 9;
`endif
    @(negedge clk);
    run_op(8'h3C, 4'd0, lat, q, r);
    vectors++;
    if (lat !== exp_lat || q !== 8'hFF || r !== 4'hF) begin
      miscompares++;
      $display("FAIL div_zero_result: got lat=%0d q=%h r=%h want lat=%0d q=ff r=f", lat, q, r, exp_lat);
    end
`ifdef DIV_ZERO_FLAG_EN
    vectors++;
    if (div_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL div_zero_set: got %b want 1", div_zero);
    end
    @(negedge clk);
    run_op(8'd200, 4'd7, lat, q, r);
    vectors++;
    if (div_zero !== 1'b0 || q !== 8'd28) begin
      miscompares++;
      $display("FAIL div_zero_clear: got flag=%b q=%0d want flag=0 q=28", div_zero, q);
    end
`endif
  endtask

  task automatic test_mid_run_start;
    int lat;
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!done && lat < 20) begin
      if (lat == 3) begin
        start = 1'b1;
        dividend = 8'd100;
        divisor = 4'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    vectors++;
    if (lat !== 9 || quotient !== 8'd28 || remainder !== 4'd4) begin
      miscompares++;
      $display("FAIL mid_run_start: got lat=%0d q=%0d r=%0d want lat=9 q=28 r=4", lat, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [7:0] q;
    logic [3:0] r;
    @(negedge clk);
    run_op(8'd200, 4'd7, lat, q, r);
    // Still in DONE here: issue the next start with no idle gap.
    dividend = 8'd255;
    divisor  = 4'd1;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!done && lat < 20) begin
      if (lat == 4) begin
        vectors++;
        if (busy !== 1'b1 || quotient !== 8'd28 || remainder !== 4'd4) begin
          miscompares++;
          $display("FAIL hold_during_run: got busy=%b q=%0d r=%0d want busy=1 q=28 r=4", busy, quotient, remainder);
        end
      end
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (lat !== 9 || quotient !== 8'd255 || remainder !== 4'd0) begin
      miscompares++;
      $display("FAIL back_to_back: got lat=%0d q=%0d r=%0d want lat=9 q=255 r=0", lat, quotient, remainder);
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    logic saw_done;
    logic [7:0] q;
    logic [3:0] r;
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, quotient, remainder} !== 14'd0) begin
      miscompares++;
      $display("FAIL abort_outputs: got busy=%b done=%b q=%0d r=%0d want all zero", busy, done, quotient, remainder);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: got done pulse=%b want 0", saw_done);
    end
    run_op(8'd5, 4'd15, lat, q, r);
    vectors++;
    if (lat !== 9 || q !== 8'd0 || r !== 4'd5) begin
      miscompares++;
      $display("FAIL after_abort: got lat=%0d q=%0d r=%0d want lat=9 q=0 r=5", lat, q, r);
    end
  endtask

  task automatic test_sweep;
    int lat;
    logic [7:0] q;
    logic [3:0] r;
    logic [7:0] exp_q;
    logic [3:0] exp_r;
    for (int dd = 0; dd < 256; dd++) begin
      for (int ds = 0; ds < 16; ds++) begin
        if (ds == 0) begin
          exp_q = 8'hFF;
          exp_r = 4'hF;
        end else begin
          exp_q = 8'(dd / ds);
          exp_r = 4'(dd % ds);
        end
        @(negedge clk);
        run_op(8'(dd), 4'(ds), lat, q, r);
        vectors++;
        if (q !== exp_q || r !== exp_r || done !== 1'b1) begin
          miscompares++;
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d done=%b want q=%0d r=%0d done=1", dd, ds, q, r, done, exp_q, exp_r);
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_mid_run_start();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_div_4bit.md
SEQ_DIV_4BIT -- requirements
Module: seq_div_4bit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only when busy=0.
REQ-004 SHALL have port dividend, input, 8 bits: unsigned dividend, captured on the accepted start.
REQ-005 SHALL have port divisor, input, 4 bits: unsigned divisor, captured on the accepted start.
REQ-006 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse marking quotient/remainder updated.
REQ-008 SHALL have port quotient, output, 8 bits: result floor(dividend/divisor).
REQ-009 SHALL have port remainder, output, 4 bits: result dividend mod divisor.
REQ-010 SHALL have port div_zero, output, 1 bit, present only with DIV_ZERO_FLAG_EN: last result was a divide by zero.

Function
REQ-011 SHALL be an unsigned restoring divider resolving one quotient bit per cycle, MSB first.
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL move IDLE->RUN on start=1, capturing operands and clearing the 4-bit iteration counter.
REQ-014 SHALL per RUN cycle: partial = {rem[3:0], next dividend bit} (5 bits); if partial >= {1'b0,divisor}, then rem = partial - divisor and q bit = 1; else rem = partial[3:0] and q bit = 0.
REQ-015 SHALL leave RUN for DONE after exactly 8 iterations; start edge at k, done high during the cycle after edge k+8.
REQ-016 SHALL hold busy=1 in RUN only and busy=0 in IDLE and DONE.
REQ-017 SHALL hold done=1 in DONE only; DONE lasts exactly one cycle.
REQ-018 SHALL change quotient/remainder only on entry to DONE; they hold their values across later RUN phases until the next DONE.
REQ-019 SHALL treat start=1 in DONE as accepted: DONE->RUN, with no idle gap required.
REQ-020 SHALL ignore start and operand changes during RUN; the captured operands are used.
REQ-021 SHALL produce quotient=8'hFF and remainder=4'hF when divisor=0.
REQ-022 SHALL produce no X on outputs for any input sequence after reset.

Reset
REQ-023 SHALL on rst_n=0, immediately and asynchronously: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, counter and working registers 0.
REQ-024 SHALL abort an in-flight operation on reset with no done pulse; outputs reset per REQ-023.
REQ-025 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL use macro DIV_ZERO_FLAG_EN to gate the divide-by-zero fast path.
REQ-027 SHALL with DIV_ZERO_FLAG_EN defined: divisor=0 on an accepted start goes directly to DONE at the next edge, giving a 1-cycle latency; div_zero is set on that DONE entry and cleared on the next normal DONE entry.
REQ-028 SHALL without DIV_ZERO_FLAG_EN: the div_zero port is absent and divisor=0 runs the full 8 iterations, with results still per REQ-021.

Structure
REQ-029 SHALL place DIVIDEND_W=8, DIVISOR_W=4, ITER_N=8 and the FSM state enum typedef in shared package div_pkg.
REQ-030 SHALL place one iteration (shift, compare, conditional subtract) in combinational sub-module div_step; seq_div_4bit holds the FSM, counter and registers.

Verification
REQ-031 SHALL verify: dividend=200, divisor=7 -> done 9 cycles after the start edge, quotient=28, remainder=4.
REQ-032 SHALL verify: dividend=255, divisor=1 -> quotient=255, remainder=0; dividend=5, divisor=15 -> quotient=0, remainder=5.
REQ-033 SHALL verify: divisor=0, dividend=0x3C -> quotient=0xFF, remainder=0xF; done latency 1 with DIV_ZERO_FLAG_EN (div_zero=1), 9 without.
REQ-034 SHALL verify: start pulsed mid-RUN with new operands -> ignored; first result unchanged; start asserted in DONE -> back-to-back operation, second done exactly 9 cycles later.
REQ-035 SHALL verify: rst_n low at iteration 4 -> outputs 0 immediately, no done pulse; a new start after release gives a correct result.
REQ-036 SHALL verify: exhaustive sweep of all 4096 operand pairs, each checked against a behavioral reference model.
